// File: rtl/src_pkg.sv
// rtl/src_pkg.sv - shared Mini SRC register-file constants and types
package src_pkg;

    localparam int SRC_WIDTH = 32;
    localparam int SRC_NREGS = 16;

    typedef logic [3:0] src_reg_idx_t;

    // Register that reads as zero when a port's BA qualifier is asserted.
    localparam src_reg_idx_t R0 = 4'd0;

endpackage

// File: rtl/src_rf_read_port.sv
// rtl/src_rf_read_port.sv - registered read port with write forwarding and BA-zero gate
module src_rf_read_port
    import src_pkg::*;
#(
    parameter int WIDTH   = SRC_WIDTH,
    parameter int DEPTH   = SRC_NREGS,
    parameter int ADDR_W  = 4,
    parameter int BA_ZERO = 1
) (
    input  logic                   clock_i,
    input  logic                   clear_i,
    input  logic                   en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   ba_i,
    input  logic                   wr_en_i,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic [WIDTH/8-1:0]     wr_be_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic [WIDTH-1:0]       regs_i [DEPTH],
    output logic [WIDTH-1:0]       data_o
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] merged;
    logic             ba_hit;

    always_comb begin
        stored = regs_i[addr_i];
        merged = stored;
        for (int i = 0; i < NB; i++) begin
            if (wr_be_i[i]) begin
                merged[8*i +: 8] = wr_data_i[8*i +: 8];
            end
        end

        ba_hit = (BA_ZERO != 0) && ba_i && (addr_i == ADDR_W'(R0));

        // Zeroing wins over forwarding so a base-address read never sees R0.
        data_d = data_q;
        if (en_i) begin
            if (ba_hit) begin
                data_d = '0;
            end else if (wr_en_i && (wr_addr_i == addr_i)) begin
                data_d = merged;
            end else begin
                data_d = stored;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!clear_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/src_reg_file.sv
// rtl/src_reg_file.sv - Mini SRC general-purpose register file, one write and two read ports
module src_reg_file
    import src_pkg::*;
#(
    parameter int WIDTH   = SRC_WIDTH,
    parameter int DEPTH   = SRC_NREGS,
    parameter int ADDR_W  = 4,
    parameter int BA_ZERO = 1
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH/8-1:0]     wr_be,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_a_en,
    input  logic [ADDR_W-1:0]      rd_a_addr,
    input  logic                   rd_a_ba,
    output logic [WIDTH-1:0]       rd_a_data,
    input  logic                   rd_b_en,
    input  logic [ADDR_W-1:0]      rd_b_addr,
    input  logic                   rd_b_ba,
    output logic [WIDTH-1:0]       rd_b_data
);

    localparam int NB = WIDTH / 8;

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("src_reg_file: WIDTH must be a multiple of 8");
    end
    if (DEPTH != 2 ** ADDR_W || DEPTH < 2) begin : g_bad_depth
        $error("src_reg_file: DEPTH must equal 2**ADDR_W and be at least 2");
    end

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    regs_d[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    src_rf_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BA_ZERO (BA_ZERO)
    ) u_port_a (
        .clock_i   (clock),
        .clear_i   (clear),
        .en_i      (rd_a_en),
        .addr_i    (rd_a_addr),
        .ba_i      (rd_a_ba),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_be_i   (wr_be),
        .wr_data_i (wr_data),
        .regs_i    (regs_q),
        .data_o    (rd_a_data)
    );

    src_rf_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BA_ZERO (BA_ZERO)
    ) u_port_b (
        .clock_i   (clock),
        .clear_i   (clear),
        .en_i      (rd_b_en),
        .addr_i    (rd_b_addr),
        .ba_i      (rd_b_ba),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_be_i   (wr_be),
        .wr_data_i (wr_data),
        .regs_i    (regs_q),
        .data_o    (rd_b_data)
    );

endmodule

// File: tb/tb_src_reg_file.sv
// tb/tb_src_reg_file.sv - self-checking bench for src_reg_file
module tb_src_reg_file;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, wr_en, a_en, a_ba, b_en, b_ba;
    logic [3:0]  wr_addr, wr_be, a_addr, b_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_a, rd_b, nb_a, nb_b;

    logic        s_clear, s_wr_en, s_a_en, s_a_ba, s_b_en, s_b_ba;
    logic [2:0]  s_wr_addr, s_a_addr, s_b_addr;
    logic [1:0]  s_wr_be;
    logic [15:0] s_wr_data, s_rd_a, s_rd_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    int          sel_q [$];

    logic [15:0] m [8];
    logic [15:0] ma, mb, mg;

    src_reg_file dut (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_a_en(a_en), .rd_a_addr(a_addr), .rd_a_ba(a_ba),
        .rd_a_data(rd_a), .rd_b_en(b_en), .rd_b_addr(b_addr), .rd_b_ba(b_ba),
        .rd_b_data(rd_b)
    );

    src_reg_file #(.BA_ZERO(0)) dut_nb (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_a_en(a_en), .rd_a_addr(a_addr), .rd_a_ba(a_ba),
        .rd_a_data(nb_a), .rd_b_en(b_en), .rd_b_addr(b_addr), .rd_b_ba(b_ba),
        .rd_b_data(nb_b)
    );

    src_reg_file #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut_s (
        .clock(clock), .clear(s_clear), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .wr_be(s_wr_be), .wr_data(s_wr_data), .rd_a_en(s_a_en), .rd_a_addr(s_a_addr),
        .rd_a_ba(s_a_ba), .rd_a_data(s_rd_a), .rd_b_en(s_b_en), .rd_b_addr(s_b_addr),
        .rd_b_ba(s_b_ba), .rd_b_data(s_rd_b)
    );

    task automatic push(input int sel, input logic [31:0] e);
        sel_q.push_back(sel);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int          sel;
        logic [31:0] e, obs;
        string       tag;
        while (exp_q.size() > 0) begin
            sel = sel_q.pop_front();
            e   = exp_q.pop_front();
            case (sel)
                0:       begin obs = rd_a;            tag = "rd_a";     end
                1:       begin obs = rd_b;            tag = "rd_b";     end
                2:       begin obs = nb_a;            tag = "nb_rd_a";  end
                3:       begin obs = nb_b;            tag = "nb_rd_b";  end
                4:       begin obs = {16'h0, s_rd_a}; tag = "sweep_a";  end
                default: begin obs = {16'h0, s_rd_b}; tag = "sweep_b";  end
            endcase
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        drain();
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    endtask

    initial begin
        clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        a_en = 1'b0; a_addr = '0; a_ba = 1'b0; b_en = 1'b0; b_addr = '0; b_ba = 1'b0;
        s_clear = 1'b0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_be = '0; s_wr_data = '0;
        s_a_en = 1'b0; s_a_addr = '0; s_a_ba = 1'b0; s_b_en = 1'b0; s_b_addr = '0; s_b_ba = 1'b0;
        foreach (m[i]) m[i] = '0;
        ma = '0; mb = '0;

        push(0, 32'h0); push(1, 32'h0);
        step();
        clear = 1'b1;

        for (int r = 1; r < 16; r++) begin
            wr(4'(r), 32'hFFFF_FFFF, 4'hF);
            step();
        end

        // Stored data visible before the mid-run clear.
        wr_en = 1'b0; a_en = 1'b1; a_addr = 4'd1; b_en = 1'b1; b_addr = 4'd15;
        push(0, 32'hFFFF_FFFF); push(1, 32'hFFFF_FFFF);
        step();

        // Clear overrides a simultaneous write and reads.
        clear = 1'b0; wr(4'd1, 32'h0000_5555, 4'hF); a_addr = 4'd2;
        push(0, 32'h0); push(1, 32'h0);
        step();
        clear = 1'b1; wr_en = 1'b0;

        for (int r = 0; r < 16; r++) begin
            a_addr = 4'(r); b_addr = 4'(15 - r);
            push(0, 32'h0); push(1, 32'h0);
            step();
        end

        a_en = 1'b0; b_en = 1'b0;
        wr(4'd3, 32'h1122_3344, 4'hF); step();
        wr(4'd3, 32'hAABB_CCDD, 4'b0101); step();
        wr_en = 1'b0; a_en = 1'b1; a_addr = 4'd3;
        push(0, 32'h11BB_33DD);
        step();

        a_en = 1'b0;
        wr(4'd5, 32'h0000_0010, 4'hF); step();
        wr(4'd5, 32'hCAFE_0000, 4'b1100);
        a_en = 1'b1; a_addr = 4'd5; b_en = 1'b1; b_addr = 4'd5;
        push(0, 32'hCAFE_0010); push(1, 32'hCAFE_0010);
        step();
        wr_en = 1'b0; b_en = 1'b0; a_addr = 4'd3;
        push(0, 32'h11BB_33DD);
        step();

        a_en = 1'b0;
        wr(4'd0, 32'h1234_5678, 4'hF); step();
        wr_en = 1'b0; a_en = 1'b1; a_addr = 4'd0; a_ba = 1'b1;
        b_en = 1'b1; b_addr = 4'd0; b_ba = 1'b0;
        push(0, 32'h0); push(1, 32'h1234_5678); push(2, 32'h1234_5678);
        step();
        b_en = 1'b0; wr(4'd0, 32'h0000_0009, 4'hF);
        push(0, 32'h0); push(2, 32'h0000_0009);
        step();
        wr_en = 1'b0; a_en = 1'b0; a_ba = 1'b0; b_en = 1'b1;
        push(1, 32'h0000_0009); push(3, 32'h0000_0009);
        step();
        a_en = 1'b1; b_ba = 1'b1;
        push(0, 32'h0000_0009); push(1, 32'h0); push(3, 32'h0000_0009);
        step();

        a_en = 1'b0; b_en = 1'b0; b_ba = 1'b0;
        wr(4'd7, 32'h0000_0077, 4'hF); step();
        wr_en = 1'b0; a_en = 1'b1; a_addr = 4'd7;
        push(0, 32'h0000_0077);
        step();
        a_en = 1'b0; wr(4'd7, 32'h0000_0088, 4'hF); a_addr = 4'd2;
        push(0, 32'h0000_0077);
        step();
        wr_en = 1'b0;
        push(0, 32'h0000_0077);
        step();
        // Write with no lanes enabled is a no-op, so forwarding yields the old R2.
        a_en = 1'b1; wr(4'd2, 32'hFFFF_FFFF, 4'h0);
        push(0, 32'h0);
        step();
        wr_en = 1'b0; a_addr = 4'd7;
        push(0, 32'h0000_0088);
        step();
        a_en = 1'b0;

        for (int c = 0; c < 10000; c++) begin
            s_clear   = ($urandom_range(0, 199) != 0);
            s_wr_en   = 1'($urandom_range(0, 1));
            s_wr_addr = 3'($urandom_range(0, 7));
            s_wr_be   = 2'($urandom_range(0, 3));
            s_wr_data = 16'($urandom);
            s_a_en    = ($urandom_range(0, 3) != 0);
            s_a_addr  = 3'($urandom_range(0, 7));
            s_a_ba    = ($urandom_range(0, 3) == 0);
            s_b_en    = ($urandom_range(0, 3) != 0);
            s_b_addr  = 3'($urandom_range(0, 7));
            s_b_ba    = ($urandom_range(0, 3) == 0);
            if (!s_clear) begin
                foreach (m[i]) m[i] = '0;
                ma = '0; mb = '0;
            end else begin
                mg = m[s_wr_addr];
                if (s_wr_be[0]) mg[7:0]  = s_wr_data[7:0];
                if (s_wr_be[1]) mg[15:8] = s_wr_data[15:8];
                if (s_a_en) begin
                    if (s_a_ba && s_a_addr == 3'd0)                ma = '0;
                    else if (s_wr_en && s_wr_addr == s_a_addr)     ma = mg;
                    else                                           ma = m[s_a_addr];
                end
                if (s_b_en) begin
                    if (s_b_ba && s_b_addr == 3'd0)                mb = '0;
                    else if (s_wr_en && s_wr_addr == s_b_addr)     mb = mg;
                    else                                           mb = m[s_b_addr];
                end
                if (s_wr_en) m[s_wr_addr] = mg;
            end
            push(4, {16'h0, ma}); push(5, {16'h0, mb});
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
